spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
SPI bus master (Mode 0: CPOL=0, CPHA=0) that drives ss_l, sclk and mosi, and samples miso. It is the initiator for the board's CPLD SPI slave (8-bit LED-out / switch-in exchange) and gives on-chip logic a start/done handshake for one full-duplex word per transfer. It sits in the host-side FPGA/CPLD between control logic and the off-chip SPI pins.

Parameters:
WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1); sclk frequency = f_clk/(2*CLK_DIV)

Ports:
clk  input  1  system clock, rising-edge
rst_l  input  1  asynchronous active-low reset
start  input  1  begin a transfer; sampled only when busy=0
tx_data  input  WIDTH  word to send; latched on the accepted start cycle
rx_data  output  WIDTH  word received; valid from done until the next accepted start
busy  output  1  high from the cycle after start is accepted until the cycle done is asserted
done  output  1  one-cycle pulse at transfer end
ss_l  output  1  slave select, active-low
sclk  output  1  SPI clock, idles low
mosi  output  1  master out, slave in
miso  input  1  master in, slave out

Behaviour:
- Reset (async, rst_l=0): ss_l=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, counters cleared. Reset mid-transfer aborts immediately with no done pulse.
- All outputs are registered. States: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> HOLD -> IDLE.
- IDLE: when start=1 at clock edge T0, latch tx_data into the shift register. At T0+1: ss_l=0, busy=1, mosi=first bit (MSB), state=SETUP.
- SETUP: wait CLK_DIV cycles, then sclk rises (-> SHIFT_HI).
- Bit k (0-based) rises at T0+1+CLK_DIV*(2k+1) and falls at T0+1+CLK_DIV*(2k+2).
- Rising edge: on the same clk edge that sets sclk=1, shift miso into the rx shift register (first sample lands in the MSB position after WIDTH shifts).
- Falling edge: on the same clk edge that sets sclk=0, mosi takes the next bit. After the final falling edge (k=WIDTH-1), mosi holds its last value and state=HOLD.
- HOLD: wait CLK_DIV cycles. Then ss_l=1, busy=0, done=1 for one cycle, rx_data updated, mosi=0, state=IDLE.
- Timing: done asserts at T0+1+CLK_DIV*(2*WIDTH+1). For defaults, that is T0+35.
- A new start is accepted in the cycle done is high (back-to-back). ss_l then stays high for exactly 1 cycle before going low again.
- start while busy=1 is ignored. tx_data changes after acceptance have no effect.
- Half-period counter width is clog2(CLK_DIV+1). CLK_DIV=1 gives sclk toggling every clk.
- miso is sampled directly without a synchronizer; the slave updates on the falling edge, which gives a half-period of setup.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: mosi sends tx_data[0] first, and miso samples shift in from the MSB side so that the first sampled bit lands in rx_data[0].
- Undefined: MSB first, as described above.
- Timing is identical in both cases.

Decomposition:
- Shared include spi_defs.vh: state encodings (IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD), SPI mode constant, default WIDTH/CLK_DIV.
- One natural sub-module: spi_sclk_gen. It contains the half-period counter, takes enable, and emits rise_tick/fall_tick strobes plus the registered sclk. spi_master contains the FSM and the shift registers.

Test Plan:
1. Loopback (miso tied to mosi), defaults, tx_data=0xA5, start at T0 -> done at T0+35, rx_data=0xA5, 16 sclk edges, ss_l low T0+1..T0+34.
2. Behavioural Mode-0 slave model returning 0x3C, tx_data=0x81 -> rx_data=0x3C; slave captures 0x81; mosi stable at every sclk rise.
3. start pulsed again at T0+10 with tx_data=0xFF during a 0x12 transfer -> ignored; slave receives 0x12; exactly one done.
4. rst_l low at T0+12 mid-transfer -> same cycle ss_l=1, sclk=0, busy=0; no done; next start yields a correct full transfer.
5. CLK_DIV=1, back-to-back starts (0x55 then 0xAA, start held high at done) -> done at T0+18 and again 18 cycles later; ss_l high exactly 1 cycle between.
6. SPI_MASTER_LSB_FIRST_EN defined, loopback, tx_data=0x01 -> mosi high on first bit only, rx_data=0x01.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode and default geometry.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } spi_state_t;

    localparam int unsigned SPI_MODE        = 0;
    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period counter with registered sclk and edge strobes.
// tick marks the last clk of every half-period; rise/fall strobe on the edge that toggles sclk.
module spi_sclk_gen
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    input  logic run,
    output logic sclk,
    output logic tick,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] cnt;

    assign tick      = en && (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_tick = tick && run && !sclk;
    assign fall_tick = tick && run && sclk;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            if (run) begin
                sclk <= ~sclk;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one full-duplex WIDTH-bit word per start/done handshake.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order (timing unchanged).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             ss_l,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    localparam int unsigned BIT_W = $clog2(WIDTH);

    spi_state_t       state;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [BIT_W-1:0] bit_cnt;
    logic             gen_en;
    logic             gen_run;
    logic             tick;
    logic             rise_tick;
    logic             fall_tick;

    logic             tx_first;
    logic             sr_first;
    logic [WIDTH-1:0] tx_data_shifted;
    logic [WIDTH-1:0] tx_sr_shifted;
    logic [WIDTH-1:0] rx_sr_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_first        = tx_data[0];
    assign sr_first        = tx_sr[0];
    assign tx_data_shifted = {1'b0, tx_data[WIDTH-1:1]};
    assign tx_sr_shifted   = {1'b0, tx_sr[WIDTH-1:1]};
    assign rx_sr_next      = {miso, rx_sr[WIDTH-1:1]};
`else
    assign tx_first        = tx_data[WIDTH-1];
    assign sr_first        = tx_sr[WIDTH-1];
    assign tx_data_shifted = {tx_data[WIDTH-2:0], 1'b0};
    assign tx_sr_shifted   = {tx_sr[WIDTH-2:0], 1'b0};
    assign rx_sr_next      = {rx_sr[WIDTH-2:0], miso};
`endif

    // Generator is held cleared in IDLE so every transfer starts on a fresh half-period.
    assign gen_en  = (state != IDLE);
    assign gen_run = (state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_l     (rst_l),
        .en        (gen_en),
        .run       (gen_run),
        .sclk      (sclk),
        .tick      (tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            ss_l    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data_shifted;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        mosi    <= tx_first;
                        ss_l    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP, SHIFT_LO: begin
                    if (rise_tick) begin
                        rx_sr <= rx_sr_next;
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (fall_tick) begin
                        if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                            state <= HOLD;
                        end else begin
                            mosi    <= sr_first;
                            tx_sr   <= tx_sr_shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= SHIFT_LO;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ss_l    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        mosi    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default instance (CLK_DIV=2) plus a CLK_DIV=1 instance.
module tb_spi_master;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_l;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy, done, ss_l, sclk, mosi, miso;

    logic       start_f;
    logic [7:0] tx_f;
    logic [7:0] rx_f;
    logic       busy_f, done_f, ss_f, sclk_f, mosi_f;

    always #5 clk = ~clk;

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .ss_l    (ss_l),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    spi_master #(.WIDTH(8), .CLK_DIV(1)) dut_f (
        .clk     (clk),
        .rst_l   (rst_l),
        .start   (start_f),
        .tx_data (tx_f),
        .rx_data (rx_f),
        .busy    (busy_f),
        .done    (done_f),
        .ss_l    (ss_f),
        .sclk    (sclk_f),
        .mosi    (mosi_f),
        .miso    (mosi_f)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 slave / bus monitor for the default instance, evaluated mid-cycle.
    logic       loopback = 1'b1;
    logic       miso_slave = 1'b0;
    logic [7:0] slave_word = '0;
    logic [7:0] s_rx = '0;
    logic [7:0] rise_bits = '0;
    int         s_idx = 0, rise_idx = 0;
    int         edge_cnt = 0, done_cnt = 0, mosi_unstable = 0;
    int         ss_first = -1, ss_last = -1;
    logic       prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    assign miso = loopback ? mosi : miso_slave;

    always @(negedge clk) begin
        if (prev_ss && !ss_l) begin
            s_idx = 0;
            s_rx = '0;
            rise_idx = 0;
            rise_bits = '0;
        end
        if (!ss_l) begin
            if (ss_first < 0) ss_first = cyc;
            ss_last = cyc;
        end
        if (!prev_sclk && sclk) begin
            if (mosi !== prev_mosi) mosi_unstable++;
            s_rx = LSB_FIRST ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
            if (rise_idx < 8) rise_bits[rise_idx] = mosi;
            rise_idx++;
        end
        if (prev_sclk && !sclk) s_idx++;
        if (sclk !== prev_sclk) edge_cnt++;
        if (done === 1'b1) done_cnt++;
        if (s_idx < 8) miso_slave = LSB_FIRST ? slave_word[s_idx] : slave_word[7 - s_idx];
        else miso_slave = 1'b0;
        prev_ss = ss_l;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    function automatic logic [7:0] send_order(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = LSB_FIRST ? w[i] : w[7 - i];
        return r;
    endfunction

    task automatic clear_mon();
        @(negedge clk);
        #2;
        edge_cnt = 0;
        done_cnt = 0;
        mosi_unstable = 0;
        ss_first = -1;
        ss_last = -1;
    endtask

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] expv,
                           output int t0, output int tdone, output logic [7:0] rx);
        @(negedge clk);
        t0 = cyc;
        tx_data = tx;
        start = 1'b1;
        exp_q.push_back(expv);
        tdone = -1;
        rx = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            tx_data = 8'($urandom);
            if (done === 1'b1) begin
                tdone = cyc;
                rx = rx_data;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ss_l !== 1'b1)   begin bad++; $display("FAIL reset_ss_l got=%b want=1", ss_l); end
        total++; if (sclk !== 1'b0)   begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        total++; if (mosi !== 1'b0)   begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", rx_data); end
        total++; if (ss_f !== 1'b1)   begin bad++; $display("FAIL reset_fast_ss_l got=%b want=1", ss_f); end
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        int t0, tdone;
        logic [7:0] rx;
        clear_mon();
        loopback = 1'b1;
        do_xfer(8'hA5, 8'hA5, t0, tdone, rx);
        total++; if (tdone - t0 != 35) begin bad++; $display("FAIL lb_latency got=%0d want=35", tdone - t0); end
        total++; if (rx !== exp_q.pop_front()) begin bad++; $display("FAIL lb_rx got=%h want=A5", rx); end
        total++; if (edge_cnt != 16) begin bad++; $display("FAIL lb_sclk_edges got=%0d want=16", edge_cnt); end
        total++; if (ss_first != t0 + 1) begin bad++; $display("FAIL lb_ss_first got=%0d want=%0d", ss_first, t0 + 1); end
        total++; if (ss_last != t0 + 34) begin bad++; $display("FAIL lb_ss_last got=%0d want=%0d", ss_last, t0 + 34); end
        total++; if (rise_bits !== send_order(8'hA5)) begin bad++; $display("FAIL lb_bit_order got=%b want=%b", rise_bits, send_order(8'hA5)); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL lb_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_slave();
        int t0, tdone;
        logic [7:0] rx;
        clear_mon();
        loopback = 1'b0;
        slave_word = 8'h3C;
        do_xfer(8'h81, 8'h3C, t0, tdone, rx);
        total++; if (tdone - t0 != 35) begin bad++; $display("FAIL slv_latency got=%0d want=35", tdone - t0); end
        total++; if (rx !== exp_q.pop_front()) begin bad++; $display("FAIL slv_rx got=%h want=3C", rx); end
        total++; if (s_rx !== 8'h81) begin bad++; $display("FAIL slv_captured got=%h want=81", s_rx); end
        total++; if (mosi_unstable != 0) begin bad++; $display("FAIL slv_mosi_stable got=%0d want=0", mosi_unstable); end
    endtask

    task automatic test_ignore_start();
        int t0, tdone;
        logic [7:0] rx;
        logic busy10;
        clear_mon();
        loopback = 1'b0;
        slave_word = 8'h9E;
        @(negedge clk);
        t0 = cyc;
        tx_data = 8'h12;
        start = 1'b1;
        exp_q.push_back(8'h9E);
        tdone = -1;
        rx = 'x;
        busy10 = 1'bx;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == t0 + 10) begin
                start = 1'b1;
                tx_data = 8'hFF;
                busy10 = busy;
            end
            if (done === 1'b1) begin
                tdone = cyc;
                rx = rx_data;
                break;
            end
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        total++; if (busy10 !== 1'b1) begin bad++; $display("FAIL ign_busy_t10 got=%b want=1", busy10); end
        total++; if (tdone - t0 != 35) begin bad++; $display("FAIL ign_latency got=%0d want=35", tdone - t0); end
        total++; if (rx !== exp_q.pop_front()) begin bad++; $display("FAIL ign_rx got=%h want=9E", rx); end
        total++; if (s_rx !== 8'h12) begin bad++; $display("FAIL ign_captured got=%h want=12", s_rx); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int t0, tdone;
        logic [7:0] rx;
        logic sclk_pre;
        clear_mon();
        loopback = 1'b1;
        @(negedge clk);
        t0 = cyc;
        tx_data = 8'h5A;
        start = 1'b1;
        for (int i = 0; i < 12 && cyc < t0 + 12; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        sclk_pre = sclk;
        rst_l = 1'b0;
        #1;
        total++; if (sclk_pre !== 1'b1) begin bad++; $display("FAIL rst_sclk_before got=%b want=1", sclk_pre); end
        total++; if (ss_l !== 1'b1) begin bad++; $display("FAIL rst_mid_ss_l got=%b want=1", ss_l); end
        total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk got=%b want=0", sclk); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_rx got=%h want=00", rx_data); end
        @(negedge clk);
        rst_l = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", done_cnt); end
        do_xfer(8'hC3, 8'hC3, t0, tdone, rx);
        total++; if (tdone - t0 != 35) begin bad++; $display("FAIL rst_after_latency got=%0d want=35", tdone - t0); end
        total++; if (rx !== exp_q.pop_front()) begin bad++; $display("FAIL rst_after_rx got=%h want=C3", rx); end
    endtask

    task automatic test_back_to_back();
        int t0, d1, d2, gap;
        logic [7:0] got1, got2;
        logic ss_t1;
        @(negedge clk);
        t0 = cyc;
        tx_f = 8'h55;
        start_f = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        ss_t1 = ss_f;
        tx_f = 8'hAA;
        exp_q.push_back(8'hAA);
        d1 = -1;
        d2 = -1;
        gap = 0;
        got1 = 'x;
        got2 = 'x;
        for (int i = 0; i < 80; i++) begin
            if (done_f === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    got1 = rx_f;
                end else begin
                    d2 = cyc;
                    got2 = rx_f;
                end
            end
            if (d2 >= 0) break;
            if (d1 >= 0 && ss_f === 1'b1) gap++;
            if (d1 >= 0 && cyc > d1) start_f = 1'b0;
            @(negedge clk);
        end
        start_f = 1'b0;
        total++; if (ss_t1 !== 1'b0) begin bad++; $display("FAIL b2b_ss_first got=%b want=0", ss_t1); end
        total++; if (d1 - t0 != 18) begin bad++; $display("FAIL b2b_latency1 got=%0d want=18", d1 - t0); end
        total++; if (d2 - d1 != 18) begin bad++; $display("FAIL b2b_latency2 got=%0d want=18", d2 - d1); end
        total++; if (got1 !== exp_q.pop_front()) begin bad++; $display("FAIL b2b_rx1 got=%h want=55", got1); end
        total++; if (got2 !== exp_q.pop_front()) begin bad++; $display("FAIL b2b_rx2 got=%h want=AA", got2); end
        total++; if (gap != 1) begin bad++; $display("FAIL b2b_ss_gap got=%0d want=1", gap); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bit_order();
        int t0, tdone;
        logic [7:0] rx;
        clear_mon();
        loopback = 1'b1;
        do_xfer(8'h01, 8'h01, t0, tdone, rx);
        total++; if (rise_bits !== send_order(8'h01)) begin bad++; $display("FAIL ord_bits got=%b want=%b", rise_bits, send_order(8'h01)); end
        total++; if ($countones(rise_bits) != 1) begin bad++; $display("FAIL ord_ones got=%0d want=1", $countones(rise_bits)); end
        total++; if (rx !== exp_q.pop_front()) begin bad++; $display("FAIL ord_rx got=%h want=01", rx); end
        total++; if (tdone - t0 != 35) begin bad++; $display("FAIL ord_latency got=%0d want=35", tdone - t0); end
    endtask

    initial begin
        rst_l = 1'b0;
        start = 1'b0;
        tx_data = '0;
        start_f = 1'b0;
        tx_f = '0;
        test_reset();
        test_loopback();
        test_slave();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_bit_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
